hazard_scoreboard: RTL and testbench

Scoreboard-based issue controller for the 5-stage MIPS pipeline. It replaces per-cycle destination comparison with a registered per-register pending counter. It sequences the PC and IF/ID register enables, inserts ID/EX bubbles, flushes IF/ID on taken branches, and freezes the whole front end while data memory is busy. It sits beside the ID stage and drives the pipeline-register enables.

---
 rtl/hazard_pkg.sv | 6 +
 rtl/sb_counter.sv | 28 ++
 rtl/hazard_scoreboard.sv | 96 +++++++++
 tb/tb_hazard_scoreboard.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared issue-controller state encoding and constants for hazard_scoreboard
package hazard_pkg;
  typedef enum logic [1:0] {RUN, STALL, FREEZE} state_t;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sb_counter.sv
// sb_counter: one register's pending-write counter; load wins over decrement, hold freezes it.
module sb_counter
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nz
);
  logic [CNT_W-1:0] nxt;
  always_comb
    nxt = hold ? cnt : load ? CNT_W'(DEPTH) : (dec && cnt != '0) ? cnt - CNT_W'(1) : cnt;
  // nz tracks the new count so the busy mask falls in the same cycle the counter reaches zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      nz  <= 1'b0;
    end else begin
      cnt <= nxt;
      nz  <= |nxt;
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: scoreboard issue controller driving PC/IF-ID enables, bubbles and flushes.
// Optional HAZARD_SB_STATS_EN adds stall-cycle and flush counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        ip_clk,
  input  logic        ip_rst_n,
  input  logic [31:0] ip_instruction,
  input  logic        ip_valid_ID,
  input  logic        ip_R_format,
  input  logic        ip_I_format,
  input  logic        ip_Lw,
  input  logic        ip_Sw,
  input  logic        ip_Beq,
  input  logic        ip_RegWrite_ID,
  input  logic [4:0]  ip_dest_ID,
  input  logic        ip_branch_taken,
  input  logic        ip_mem_busy,
  output logic        op_pc_we,
  output logic        op_ifid_we,
  output logic        op_flush_IF,
  output logic        op_bubble,
  output logic        op_stall,
  output logic [31:0] op_busy_mask
`ifdef HAZARD_SB_STATS_EN
  ,
  output logic [31:0] op_stall_cycles,
  output logic [15:0] op_flush_count
`endif
);
  state_t state, next;
  logic [CNT_W-1:0] cnt [32];
  logic [31:0] nz;
  logic [4:0] rs, rt;
  logic use_rs, use_rt, hazard, issue, wr;
  logic pc_we, ifid_we, flush, bubble, stall;
  assign rs = ip_instruction[25:21];
  assign rt = ip_instruction[20:16];
  assign use_rs = ip_R_format | ip_I_format | ip_Lw | ip_Sw | ip_Beq;
  assign use_rt = ip_R_format | ip_Sw | ip_Beq;
  // a NOP only names $0, which is never pending, so excluding it changes nothing
  assign hazard = ip_valid_ID & (ip_instruction != NOP) &
                  ((use_rs & (cnt[rs] != '0)) | (use_rt & (cnt[rt] != '0)));
  assign wr = issue & ip_RegWrite_ID & (ip_dest_ID != REG_ZERO);
  assign cnt[0] = '0;
  assign nz[0] = 1'b0;
  for (genvar g = 1; g < 32; g++) begin : g_cnt
    sb_counter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_cnt (
      .clk  (ip_clk),
      .rst_n(ip_rst_n),
      .hold (ip_mem_busy),
      .load (wr & (ip_dest_ID == 5'(g))),
      .dec  (1'b1),
      .cnt  (cnt[g]),
      .nz   (nz[g])
    );
  end
  always_comb begin
    next = state;
    {pc_we, ifid_we, flush, bubble, stall, issue} = '0;
    if (ip_mem_busy) next = FREEZE;
    else if (ip_branch_taken) begin
      {pc_we, ifid_we, flush, bubble} = '1;
      next = RUN;
    end else if (hazard) begin
      {stall, bubble} = '1;
      next = STALL;
    end else begin
      {pc_we, ifid_we} = '1;
      issue = ip_valid_ID;
      next = RUN;
    end
  end
  always_ff @(posedge ip_clk or negedge ip_rst_n)
    if (!ip_rst_n) state <= RUN;
    else state <= next;
  assign op_pc_we     = ip_rst_n & pc_we;
  assign op_ifid_we   = ip_rst_n & ifid_we;
  assign op_flush_IF  = ip_rst_n & flush;
  assign op_bubble    = ip_rst_n & bubble;
  assign op_stall     = ip_rst_n & stall;
  assign op_busy_mask = nz;
`ifdef HAZARD_SB_STATS_EN
  always_ff @(posedge ip_clk or negedge ip_rst_n)
    if (!ip_rst_n) begin
      op_stall_cycles <= '0;
      op_flush_count  <= '0;
    end else begin
      if (op_stall) op_stall_cycles <= op_stall_cycles + 32'd1;
      if (op_flush_IF && op_flush_count != 16'hFFFF) op_flush_count <= op_flush_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus random traffic checked against a per-register
// remaining-latency model; covers stats ports when HAZARD_SB_STATS_EN is defined.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] instr;
  logic valid, R, I, Lw, Sw, Beq, rw, br, mb;
  logic [4:0] dest;
  logic pc_we, ifid_we, flush, bubble, stall;
  logic [31:0] mask;
`ifdef HAZARD_SB_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif
  int rem [32];
  int sc, fc;
  int checks = 0, errors = 0;
  bit last_stall, last_pcwe, last_flush, last_bubble;
  logic [31:0] last_mask;
  int n;

  hazard_scoreboard dut (
    .ip_clk(clk), .ip_rst_n(rst_n), .ip_instruction(instr), .ip_valid_ID(valid),
    .ip_R_format(R), .ip_I_format(I), .ip_Lw(Lw), .ip_Sw(Sw), .ip_Beq(Beq),
    .ip_RegWrite_ID(rw), .ip_dest_ID(dest), .ip_branch_taken(br), .ip_mem_busy(mb),
    .op_pc_we(pc_we), .op_ifid_we(ifid_we), .op_flush_IF(flush), .op_bubble(bubble),
    .op_stall(stall), .op_busy_mask(mask)
`ifdef HAZARD_SB_STATS_EN
    , .op_stall_cycles(stall_cycles), .op_flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // cls: 0=R 1=I 2=Lw 3=Sw 4=Beq 5=no operand class
  task automatic set_id(input bit v, input int cls, input int s, input int t, input int d, input bit w);
    logic [4:0] oh;
    oh = 5'b10000 >> cls;
    valid = v;
    {R, I, Lw, Sw, Beq} = (cls < 5) ? oh : 5'b0;
    instr = {6'($urandom), 5'(s), 5'(t), 16'($urandom)};
    dest = 5'(d);
    rw = w;
  endtask

  task automatic clear_model();
    for (int r = 0; r < 32; r++) rem[r] = 0;
    sc = 0;
    fc = 0;
  endtask

  task automatic step();
    logic [4:0] s, t;
    logic [31:0] em;
    bit urs, urt, hz, iss, epc, eif, efl, ebu, est;
    s = instr[25:21];
    t = instr[20:16];
    urs = R | I | Lw | Sw | Beq;
    urt = R | Sw | Beq;
    hz = valid && ((urs && rem[s] > 0) || (urt && rem[t] > 0));
    {epc, eif, efl, ebu, est, iss} = '0;
    if (rst_n && !mb) begin
      if (br) {epc, eif, efl, ebu} = '1;
      else if (hz) {ebu, est} = '1;
      else begin
        {epc, eif} = '1;
        iss = valid;
      end
    end
    for (int r = 0; r < 32; r++) em[r] = rem[r] > 0;
    #4;
    chk("pc_we", pc_we, epc);
    chk("ifid_we", ifid_we, eif);
    chk("flush_IF", flush, efl);
    chk("bubble", bubble, ebu);
    chk("stall", stall, est);
    chk("busy_mask", mask, em);
`ifdef HAZARD_SB_STATS_EN
    chk("stall_cycles", stall_cycles, sc);
    chk("flush_count", 32'(flush_count), fc);
`endif
    {last_stall, last_pcwe, last_flush, last_bubble} = {stall, pc_we, flush, bubble};
    last_mask = mask;
    @(posedge clk);
    #1;
    if (!rst_n) clear_model();
    else if (!mb) begin
      for (int r = 0; r < 32; r++) rem[r] = (rem[r] > 0) ? rem[r] - 1 : 0;
      if (iss && rw && dest != 5'd0) rem[dest] = 3;
    end
    if (est) sc++;
    if (efl && fc < 65535) fc++;
  endtask

  task automatic idle(input int k);
    set_id(0, 5, 0, 0, 0, 0);
    repeat (k) step();
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0;
    br = 1'b1;
    mb = 1'b0;
    set_id(1, 0, 1, 2, 3, 1);
    #12;
    chk("rst_pc_we", pc_we, 0);
    chk("rst_ifid_we", ifid_we, 0);
    chk("rst_flush", flush, 0);
    chk("rst_bubble", bubble, 0);
    chk("rst_mask", mask, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    br = 1'b0;
    // producer add $3, then consumer reading $3 as rt
    set_id(1, 0, 1, 2, 3, 1);
    step();
    set_id(1, 0, 1, 3, 4, 1);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!last_stall) break;
      n++;
    end
    chk("raw_stall_len", n, 3);
    chk("raw_issue_mask3", last_mask[3], 0);
`ifdef HAZARD_SB_STATS_EN
    chk("stats_first", stall_cycles, 3);
`endif
    idle(4);
    // $0 writes never create hazards
    set_id(1, 0, 1, 2, 0, 1);
    step();
    set_id(1, 0, 0, 0, 0, 1);
    step();
    chk("zero_no_stall", last_stall, 0);
    chk("zero_mask", last_mask, 0);
    idle(1);
    // load $5, dependent store held across a 2-cycle freeze
    set_id(1, 2, 1, 0, 5, 1);
    step();
    set_id(1, 3, 2, 5, 0, 0);
    n = 0;
    step();
    if (!last_pcwe) n++;
    mb = 1'b1;
    repeat (2) begin
      step();
      if (!last_pcwe) n++;
      chk("freeze_mask5", last_mask[5], 1);
    end
    mb = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (last_pcwe) break;
      n++;
    end
    chk("freeze_hold_len", n, 5);
    idle(4);
    // taken branch while stalled on $7 drops the stalled instruction
    set_id(1, 0, 1, 2, 7, 1);
    step();
    set_id(1, 0, 7, 1, 8, 1);
    step();
    chk("br_pre_stall", last_stall, 1);
    br = 1'b1;
    step();
    chk("br_flush", last_flush, 1);
    chk("br_bubble", last_bubble, 1);
    br = 1'b0;
    set_id(1, 1, 1, 0, 9, 1);
    step();
    chk("br_run", last_pcwe, 1);
    idle(4);
    // reissue to $4 while its counter is 1 reloads it
    set_id(1, 0, 1, 2, 4, 1);
    step();
    idle(2);
    set_id(1, 1, 1, 0, 4, 1);
    step();
    set_id(1, 0, 4, 2, 6, 1);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!last_stall) break;
      n++;
    end
    chk("reissue_stall_len", n, 3);
    idle(4);
    // random traffic
    repeat (400) begin
      set_id($urandom_range(0, 9) < 8, $urandom_range(0, 5), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1));
      br = $urandom_range(0, 9) == 0;
      mb = $urandom_range(0, 9) == 0;
      step();
    end
    br = 1'b0;
    mb = 1'b0;
    idle(4);
    // asynchronous reset in the middle of a stall
    set_id(1, 0, 1, 2, 6, 1);
    step();
    set_id(1, 0, 6, 2, 9, 1);
    step();
    chk("mid_pre_stall", last_stall, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_bubble", bubble, 0);
    chk("mid_rst_pc_we", pc_we, 0);
    chk("mid_rst_mask", mask, 0);
`ifdef HAZARD_SB_STATS_EN
    chk("mid_rst_stall_cycles", stall_cycles, 0);
    chk("mid_rst_flush_count", 32'(flush_count), 0);
`endif
    clear_model();
    #1;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_no_stall", last_stall, 0);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
